// File: rtl/conv_layer_load_sequencer_pkg.sv
// Shared types and sizing helpers for the conv-layer load sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StLoadI,
        StCheck,
        StCompute,
        StDone,
        StErr
    } seq_state_t;

    typedef logic [15:0] bf16_t;

    // Elements in n tensors of ch channels, each dim x dim.
    function automatic int unsigned total_elems(int unsigned n, int unsigned ch,
                                                int unsigned dim);
        return n * ch * dim * dim;
    endfunction

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_layer_load_sequencer_if.sv
// Stream, storage-write and compute handshake bundle for the load sequencer.
interface conv_layer_load_sequencer_if #(
    parameter int unsigned BW = 16
);
    logic          start;
    logic          abort;
    logic          s_valid;
    logic [BW-1:0] s_data;
    logic          s_ready;
    logic          w_write_en;
    logic [BW-1:0] w_data;
    logic          w_full;
    logic          i_write_en;
    logic [BW-1:0] i_data;
    logic          i_full;
    logic          compute_start;
    logic          compute_done;
    logic          busy;
    logic          done;
    logic          error;

    // Sequencer side.
    modport slave (
        input  start, abort, s_valid, s_data, w_full, i_full, compute_done,
        output s_ready, w_write_en, w_data, i_write_en, i_data, compute_start,
               busy, done, error
    );

    // Controller / stream source / storage side.
    modport master (
        output start, abort, s_valid, s_data, w_full, i_full, compute_done,
        input  s_ready, w_write_en, w_data, i_write_en, i_data, compute_start,
               busy, done, error
    );
endinterface

// File: rtl/conv_layer_load_sequencer_counter.sv
// Word counter for one load phase; last_o flags the final word of the phase.
module load_counter #(
    parameter int unsigned TOTAL = 8,
    parameter int unsigned CW    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic last_o
);
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == CW'(TOTAL - 1));

endmodule

// File: rtl/conv_layer_load_sequencer.sv
// Routes one layer's word stream into weight then ifmap storage, verifies both
// storages report full, then launches compute and waits for completion.
module conv_layer_load_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned K  = 10,
    parameter int unsigned C  = 3,
    parameter int unsigned wH = 5,
    parameter int unsigned iH = 32,
    parameter int unsigned BW = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    conv_layer_load_sequencer_if.slave  bus
);
    localparam int unsigned WTotal = total_elems(K, C, wH);
    localparam int unsigned ITotal = total_elems(1, C, iH);
    localparam int unsigned CW     = $clog2(max_u(WTotal, ITotal) + 1);

    seq_state_t state_q, state_d;
    logic       compute_start_q, compute_start_d;
    logic       load_w, load_i, xfer, start_acc;
    logic       w_we, i_we, w_last, i_last;
    logic       w_clr, i_clr;

    always_comb begin
        load_w    = (state_q == StLoadW);
        load_i    = (state_q == StLoadI);
        // abort masks ready so no word is strobed in the abort cycle.
        xfer      = bus.s_valid && (load_w || load_i) && !bus.abort;
        w_we      = xfer && load_w;
        i_we      = xfer && load_i;
        start_acc = bus.start && !bus.abort && ((state_q == StIdle) || (state_q == StDone));
        w_clr     = bus.abort || start_acc || (w_we && w_last);
        i_clr     = bus.abort || start_acc || (i_we && i_last);
    end

    load_counter #(
        .TOTAL (WTotal),
        .CW    (CW)
    ) u_w_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (w_we),
        .clr_i  (w_clr),
        .last_o (w_last)
    );

    load_counter #(
        .TOTAL (ITotal),
        .CW    (CW)
    ) u_i_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (i_we),
        .clr_i  (i_clr),
        .last_o (i_last)
    );

    always_comb begin
        state_d         = state_q;
        compute_start_d = 1'b0;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) state_d = StLoadW;
                end
                StLoadW: begin
                    if (w_we && w_last) begin
                        state_d = StLoadI;
                    end else if (bus.w_full) begin
                        state_d = StErr;
                    end
                end
                StLoadI: begin
                    if (i_we && i_last) begin
                        state_d = StCheck;
                    end else if (bus.i_full) begin
                        state_d = StErr;
                    end
                end
                StCheck: begin
                    if (bus.w_full && bus.i_full) begin
                        state_d         = StCompute;
                        compute_start_d = 1'b1;
                    end else begin
                        state_d = StErr;
                    end
                end
                StCompute: begin
                    if (bus.compute_done) state_d = StDone;
                end
                StErr: begin
                    state_d = StErr;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            compute_start_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            compute_start_q <= compute_start_d;
        end
    end

    always_comb begin
        bus.s_ready       = (load_w || load_i) && !bus.abort;
        bus.w_write_en    = w_we;
        bus.i_write_en    = i_we;
        bus.w_data        = w_we ? bus.s_data : {BW{1'b0}};
        bus.i_data        = i_we ? bus.s_data : {BW{1'b0}};
        bus.compute_start = compute_start_q;
        bus.busy          = load_w || load_i || (state_q == StCheck) || (state_q == StCompute);
        bus.done          = (state_q == StDone);
        bus.error         = (state_q == StErr);
    end

endmodule

// File: tb/tb_conv_layer_load_sequencer.sv
// Scoreboard bench for conv_layer_load_sequencer with K=2, C=1, wH=2, iH=3.
module tb_conv_layer_load_sequencer;
    import conv_pkg::*;

    localparam int unsigned WTot = 8;
    localparam int unsigned ITot = 9;

    logic clk;
    logic rst_n;
    logic stor_clr;
    int   w_cap;
    int   w_cnt, i_cnt;
    int   tests, fails;
    int   w_strobes, i_strobes, cs_cnt;
    bf16_t exp_w[$];
    bf16_t exp_i[$];

    conv_layer_load_sequencer_if #(.BW(16)) bus ();

    conv_layer_load_sequencer #(
        .K  (2),
        .C  (1),
        .wH (2),
        .iH (3),
        .BW (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage models: count strobes, raise full at capacity.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_cnt <= 0;
            i_cnt <= 0;
        end else if (stor_clr) begin
            w_cnt <= 0;
            i_cnt <= 0;
        end else begin
            if (bus.w_write_en) w_cnt <= w_cnt + 1;
            if (bus.i_write_en) i_cnt <= i_cnt + 1;
        end
    end
    assign bus.w_full = (w_cnt >= w_cap);
    assign bus.i_full = (i_cnt >= ITot);

    function automatic logic [38:0] outs();
        return {bus.s_ready, bus.w_write_en, bus.i_write_en, bus.compute_start, bus.busy,
                bus.done, bus.error, bus.w_data, bus.i_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scoreboard();
        bf16_t e;
        forever begin
            @(negedge clk);
            tests++;
            if (bus.w_write_en) begin
                w_strobes++;
                if (exp_w.size() == 0) begin
                    fails++;
                    $display("FAIL w_strobe: unexpected write data=%h, none expected", bus.w_data);
                end else begin
                    e = exp_w.pop_front();
                    if (bus.w_data !== e) begin
                        fails++;
                        $display("FAIL w_data: got %h expected %h", bus.w_data, e);
                    end
                end
            end else if (bus.w_data !== 16'h0) begin
                fails++;
                $display("FAIL w_data_idle: got %h expected 0000", bus.w_data);
            end
            tests++;
            if (bus.i_write_en) begin
                i_strobes++;
                if (exp_i.size() == 0) begin
                    fails++;
                    $display("FAIL i_strobe: unexpected write data=%h, none expected", bus.i_data);
                end else begin
                    e = exp_i.pop_front();
                    if (bus.i_data !== e) begin
                        fails++;
                        $display("FAIL i_data: got %h expected %h", bus.i_data, e);
                    end
                end
            end else if (bus.i_data !== 16'h0) begin
                fails++;
                $display("FAIL i_data_idle: got %h expected 0000", bus.i_data);
            end
            if (bus.compute_start) cs_cnt++;
        end
    endtask

    task automatic clear_storage();
        stor_clr = 1'b1;
        tick();
        stor_clr = 1'b0;
    endtask

    task automatic push_word(input int n, output bf16_t d);
        d = bf16_t'(32'h3F80 + n);
        if (n < int'(WTot)) exp_w.push_back(d);
        else exp_i.push_back(d);
    endtask

    // Full layer: start, 17 words, check, compute, done after compute_done.
    task automatic run_layer(input bit bubble, input bit glitch, input string tag);
        int w0, i0, c0;
        bf16_t d;
        w0 = w_strobes; i0 = i_strobes; c0 = cs_cnt;
        bus.start = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++; $display("FAIL %s idle_busy: got %b expected 0", tag, bus.busy);
        end
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < int'(WTot + ITot); n++) begin
            bus.s_valid = 1'b1;
            push_word(n, d);
            bus.s_data = d;
            if (glitch && n == 3) bus.start = 1'b1;
            @(negedge clk);
            tests++;
            if (bus.s_ready !== 1'b1) begin
                fails++; $display("FAIL %s s_ready word %0d: got %b expected 1", tag, n, bus.s_ready);
            end
            tick();
            bus.start = 1'b0;
            if (bubble && n < int'(WTot + ITot) - 1) begin
                bus.s_valid = 1'b0;
                bus.s_data  = 16'hDEAD;
                @(negedge clk);
                tick();
            end
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.busy, bus.compute_start, bus.s_ready} !== 3'b100) begin
            fails++;
            $display("FAIL %s check_cycle busy/cs/ready: got %b expected 100", tag,
                     {bus.busy, bus.compute_start, bus.s_ready});
        end
        tick();
        @(negedge clk);
        tests++;
        if (bus.compute_start !== 1'b1) begin
            fails++; $display("FAIL %s compute_start: got %b expected 1", tag, bus.compute_start);
        end
        tick();
        bus.start = glitch;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if ({bus.compute_start, bus.busy, bus.done} !== 3'b010) begin
                fails++;
                $display("FAIL %s compute_wait %0d cs/busy/done: got %b expected 010", tag, k,
                         {bus.compute_start, bus.busy, bus.done});
            end
            tick();
            bus.start = 1'b0;
        end
        bus.compute_done = 1'b1;
        @(negedge clk);
        tick();
        bus.compute_done = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            fails++; $display("FAIL %s done/busy: got %b expected 10", tag, {bus.done, bus.busy});
        end
        tests++;
        if ((w_strobes - w0) != int'(WTot) || (i_strobes - i0) != int'(ITot)) begin
            fails++;
            $display("FAIL %s strobe_count: got w=%0d i=%0d expected w=8 i=9", tag,
                     w_strobes - w0, i_strobes - i0);
        end
        tests++;
        if ((cs_cnt - c0) != 1) begin
            fails++; $display("FAIL %s cs_pulses: got %0d expected 1", tag, cs_cnt - c0);
        end
        tests++;
        if (exp_w.size() != 0 || exp_i.size() != 0) begin
            fails++;
            $display("FAIL %s leftover: got w=%0d i=%0d pending expected 0", tag, exp_w.size(),
                     exp_i.size());
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (outs() !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", outs());
        end
        #3 rst_n = 1'b1;
        tick();
        @(negedge clk);
        tests++;
        if (outs() !== '0) begin
            fails++; $display("FAIL idle_outputs: got %h expected 0", outs());
        end
        tick();
    endtask

    task automatic test_normal();
        clear_storage();
        run_layer(1'b0, 1'b0, "normal");
    endtask

    task automatic test_bubbled();
        clear_storage();
        run_layer(1'b1, 1'b0, "bubbled");
    endtask

    task automatic test_ignored_start();
        clear_storage();
        run_layer(1'b0, 1'b1, "ignored_start");
    endtask

    task automatic test_early_full();
        bf16_t d;
        clear_storage();
        w_cap = 5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            bus.s_valid = 1'b1;
            push_word(n, d);
            bus.s_data = d;
            tick();
        end
        bus.s_valid = 1'b0;
        tick();
        @(negedge clk);
        tests++;
        if ({bus.error, bus.s_ready, bus.busy} !== 3'b100) begin
            fails++;
            $display("FAIL early_full err/ready/busy: got %b expected 100",
                     {bus.error, bus.s_ready, bus.busy});
        end
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 16'hBEEF;
        bus.start   = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.w_write_en !== 1'b0) begin
            fails++; $display("FAIL err_no_strobe: got %b expected 0", bus.w_write_en);
        end
        tick();
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.error, bus.busy} !== 2'b10) begin
            fails++; $display("FAIL err_start_ignored: got %b expected 10", {bus.error, bus.busy});
        end
        tick();
        bus.abort = 1'b1;
        @(negedge clk);
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.error, bus.busy, bus.done} !== 3'b000) begin
            fails++;
            $display("FAIL err_abort: got %b expected 000", {bus.error, bus.busy, bus.done});
        end
        tick();
        w_cap = WTot;
    endtask

    task automatic test_abort_mid_load();
        bf16_t d;
        clear_storage();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < int'(WTot) + 3; n++) begin
            bus.s_valid = 1'b1;
            push_word(n, d);
            bus.s_data = d;
            tick();
        end
        bus.s_data = bf16_t'(32'h3F80 + WTot + 3);
        bus.abort  = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.i_write_en, bus.s_ready} !== 2'b00) begin
            fails++;
            $display("FAIL abort_strobe i_we/ready: got %b expected 00",
                     {bus.i_write_en, bus.s_ready});
        end
        tick();
        bus.abort   = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.busy, bus.done, bus.error} !== 3'b000) begin
            fails++;
            $display("FAIL abort_idle: got %b expected 000", {bus.busy, bus.done, bus.error});
        end
        tick();
        clear_storage();
        run_layer(1'b0, 1'b0, "restart_after_abort");
    endtask

    task automatic test_async_reset();
        bf16_t d;
        int c0;
        clear_storage();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < int'(WTot + ITot); n++) begin
            bus.s_valid = 1'b1;
            push_word(n, d);
            bus.s_data = d;
            tick();
        end
        bus.s_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (outs() !== '0) begin
            fails++; $display("FAIL async_reset_outputs: got %h expected 0", outs());
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        c0 = cs_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if ({bus.compute_start, bus.busy} !== 2'b00) begin
                fails++;
                $display("FAIL post_reset %0d cs/busy: got %b expected 00", k,
                         {bus.compute_start, bus.busy});
            end
        end
        tests++;
        if (cs_cnt != c0) begin
            fails++; $display("FAIL post_reset_pulses: got %0d expected 0", cs_cnt - c0);
        end
        tick();
        run_layer(1'b0, 1'b0, "first_run_after_reset");
    endtask

    initial begin
        tests = 0; fails = 0;
        w_strobes = 0; i_strobes = 0; cs_cnt = 0;
        w_cap = WTot;
        stor_clr = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = 16'h0;
        bus.compute_done = 1'b0;
        fork
            scoreboard();
        join_none
        test_reset();
        test_normal();
        test_bubbled();
        test_early_full();
        test_abort_mid_load();
        test_ignored_start();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
